sc_vehiculo_lane_shifter: RTL and testbench
===========================================

// Module: sc_vehiculo_lane_shifter
// PURPOSE
//  Vehicle lane register driven by the level-control state machine (NVE FSM).
//  Captures the level pattern the FSM presents while LOAD_SHIFT=1.
//  While LOAD_SHIFT=0, rotates the pattern at a rate chosen by VEL_SELECT.
//  Drives the lane pattern to the display/collision logic and issues a per-step tick.
// PARAMETERS
//  DATAWIDTH_BUS  8           lane width (bits); must be >=2
//  CNT_WIDTH      25          prescaler counter width
//  DIV_VEL1       25000000    clocks per step, VEL_SELECT=01 (slow)
//  DIV_VEL2       12500000    clocks per step, VEL_SELECT=10
//  DIV_VEL3       6250000     clocks per step, VEL_SELECT=11 (fast); all DIV >=2
//  DIR            0           0 = rotate left (MSB->LSB wrap), 1 = rotate right
// PORTS
//  SC_STATEMACHINE_NVE_CLOCK_50  in   1         50 MHz system clock
//  SC_STATEMACHINE_NVE_RESET     in   1         async reset, active-high
//  LANE_LOAD_SHIFT_IN            in   1         1 = load/hold, 0 = shift mode (from NVE FSM)
//  LANE_REGNIVEL_IN              in   W         level pattern; nonzero only in FSM load states
//  LANE_VEL_SELECT_IN            in   2         00 stop, 01/10/11 speed 1/2/3
//  LANE_PAUSA_IN                 in   1         1 = freeze counter and lane
//  LANE_PATTERN_OUT              out  W         current lane pattern (registered)
//  LANE_TICK_OUT                 out  1         1-cycle pulse, coincident with each rotation
//  LANE_STATE_OUT                out  2         00 IDLE, 01 ARMED, 10 RUN, 11 PAUSE
// BEHAVIOUR
//  Reset (async, immediate): PATTERN=0, counter=0, TICK=0, STATE=IDLE.
//  Priority per edge: LOAD_SHIFT=1 > PAUSA=1 > shift.
//  Load (LOAD_SHIFT=1): counter<=0; TICK<=0.
//   - REGNIVEL!=0: PATTERN<=REGNIVEL; STATE<=ARMED.
//   - REGNIVEL==0: PATTERN holds; STATE holds, except PAUSE->ARMED and RUN->ARMED.
//  Pause (LOAD_SHIFT=0, PAUSA=1): counter, PATTERN and STATE(->PAUSE) freeze.
//   - TICK<=0. Ignored in IDLE, which stays IDLE.
//   - On PAUSA release: resume from the frozen counter value, STATE<=RUN.
//  Shift (LOAD_SHIFT=0, PAUSA=0, STATE!=IDLE):
//   - VEL=00: counter held at 0, no ticks, STATE<=ARMED.
//   - VEL!=00: STATE<=RUN. DIV = DIV_VELn.
//   - Counter increments each edge; terminal when counter>=DIV-1 (>= covers a speed change mid-count).
//   - At terminal: counter<=0, PATTERN rotates one position, TICK<=1 on the same edge.
//   - First rotation occurs on the DIV-th edge after entering shift mode.
//   - Rotate left: {P[W-2:0],P[W-1]}. Rotate right: {P[0],P[W-1:1]}.
//  IDLE: nothing loaded yet. No counting, no ticks, PATTERN=0.
//  Leaving IDLE requires a nonzero load.
//  Pattern all-ones or all-zeros rotates to itself; TICK still pulses (all-ones case).
//  Counter width must hold DIV_VEL1-1; no arithmetic overflow otherwise.
// TESTING (bench params: W=8, DIV_VEL1=8, DIV_VEL2=4, DIV_VEL3=2, DIR=0)
//  1 Reset; LOAD=1, REGNIVEL=0xC3 for 1 clk; then LOAD=0, VEL=01
//    -> STATE=ARMED then RUN; TICK on 8th edge, PATTERN=0x87; next TICK 8 edges later, 0x0F.
//  2 Loaded 0x81, VEL=11 -> TICK every 2 edges; PATTERN 0x03,0x06,0x0C...
//    Check no TICK while VEL=00.
//  3 VEL=01, counter reaches 5, switch VEL=11
//    -> wrap and rotate on the next edge; thereafter period 2.
//  4 RUN, assert PAUSA for 10 clks -> PATTERN/counter frozen, STATE=PAUSE, no TICK.
//    Release -> remaining count completes, then TICK.
//  5 LOAD=1 with REGNIVEL=0 after running at 0x0F
//    -> PATTERN stays 0x0F, counter=0, STATE=ARMED. From reset, LOAD=0, VEL=01 -> stays IDLE.
//  6 Assert RESET mid-count between clock edges
//    -> PATTERN=0, TICK=0, STATE=IDLE before the next edge.

Source files
------------

// File: rtl/sc_vehiculo_lane_shifter.sv
// Vehicle lane register for the NVE level FSM: it loads a level pattern, then rotates it at a
// selectable speed, with pause support and a one-cycle tick on each rotation.
module sc_vehiculo_lane_shifter #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int CNT_WIDTH     = 25,
    parameter int DIV_VEL1      = 25000000,
    parameter int DIV_VEL2      = 12500000,
    parameter int DIV_VEL3      = 6250000,
    parameter bit DIR           = 1'b0
) (
    input  logic                     SC_STATEMACHINE_NVE_CLOCK_50,
    input  logic                     SC_STATEMACHINE_NVE_RESET,
    input  logic                     LANE_LOAD_SHIFT_IN,
    input  logic [DATAWIDTH_BUS-1:0] LANE_REGNIVEL_IN,
    input  logic [1:0]               LANE_VEL_SELECT_IN,
    input  logic                     LANE_PAUSA_IN,
    output logic [DATAWIDTH_BUS-1:0] LANE_PATTERN_OUT,
    output logic                     LANE_TICK_OUT,
    output logic [1:0]               LANE_STATE_OUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } lane_state_t;

    lane_state_t              state, state_next;
    logic [DATAWIDTH_BUS-1:0] pattern, pattern_next;
    logic [CNT_WIDTH-1:0]     cnt, cnt_next;
    logic                     tick, tick_next;
    logic [CNT_WIDTH-1:0]     div_m1;
    logic [DATAWIDTH_BUS-1:0] rotated;

    // Terminal count per speed; speed 0 never reaches the terminal comparison.
    always_comb begin
        case (LANE_VEL_SELECT_IN)
            2'b01:   div_m1 = CNT_WIDTH'(DIV_VEL1 - 1);
            2'b10:   div_m1 = CNT_WIDTH'(DIV_VEL2 - 1);
            2'b11:   div_m1 = CNT_WIDTH'(DIV_VEL3 - 1);
            default: div_m1 = '0;
        endcase
    end

    assign rotated = DIR ? {pattern[0], pattern[DATAWIDTH_BUS-1:1]}
                         : {pattern[DATAWIDTH_BUS-2:0], pattern[DATAWIDTH_BUS-1]};

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        pattern_next = pattern;
        cnt_next     = cnt;
        tick_next    = 1'b0;

        if (LANE_LOAD_SHIFT_IN) begin
            cnt_next = '0;
            if (LANE_REGNIVEL_IN != '0) begin
                pattern_next = LANE_REGNIVEL_IN;
                state_next   = ARMED;
            end else if (state == RUN || state == PAUSE) begin
                state_next = ARMED;
            end
        end else if (LANE_PAUSA_IN) begin
            if (state != IDLE)
                state_next = PAUSE;
        end else if (state != IDLE) begin
            if (LANE_VEL_SELECT_IN == 2'b00) begin
                cnt_next   = '0;
                state_next = ARMED;
            end else begin
                state_next = RUN;
                // Using >= lets a switch to a faster speed in the middle of a count end that count on the next edge.
                if (cnt >= div_m1) begin
                    cnt_next     = '0;
                    pattern_next = rotated;
                    tick_next    = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SC_STATEMACHINE_NVE_CLOCK_50 or posedge SC_STATEMACHINE_NVE_RESET) begin
        if (SC_STATEMACHINE_NVE_RESET) begin
            state   <= IDLE;
            pattern <= '0;
            cnt     <= '0;
            tick    <= 1'b0;
        end else begin
            state   <= state_next;
            pattern <= pattern_next;
            cnt     <= cnt_next;
            tick    <= tick_next;
        end
    end

    assign LANE_PATTERN_OUT = pattern;
    assign LANE_TICK_OUT    = tick;
    assign LANE_STATE_OUT   = state;

endmodule

// File: tb/tb_sc_vehiculo_lane_shifter.sv
// Directed bench for sc_vehiculo_lane_shifter with short dividers (8/4/2) and left rotation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sc_vehiculo_lane_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_shift = 1'b0;
    logic [7:0] regnivel = 8'h00;
    logic [1:0] vel = 2'b00;
    logic       pausa = 1'b0;
    logic [7:0] pattern;
    logic       tick;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int ticks;

    localparam logic [1:0] S_IDLE = 2'b00, S_ARMED = 2'b01, S_RUN = 2'b10, S_PAUSE = 2'b11;

    sc_vehiculo_lane_shifter #(
        .DATAWIDTH_BUS(8),
        .CNT_WIDTH    (4),
        .DIV_VEL1     (8),
        .DIV_VEL2     (4),
        .DIV_VEL3     (2),
        .DIR          (1'b0)
    ) dut (
        .SC_STATEMACHINE_NVE_CLOCK_50(clk),
        .SC_STATEMACHINE_NVE_RESET   (rst),
        .LANE_LOAD_SHIFT_IN          (load_shift),
        .LANE_REGNIVEL_IN            (regnivel),
        .LANE_VEL_SELECT_IN          (vel),
        .LANE_PAUSA_IN               (pausa),
        .LANE_PATTERN_OUT            (pattern),
        .LANE_TICK_OUT               (tick),
        .LANE_STATE_OUT              (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tick) cnt++;
        end
    endtask

    task automatic load(input logic [7:0] value);
        load_shift = 1'b1;
        regnivel   = value;
        clk_n(1);
        load_shift = 1'b0;
        regnivel   = 8'h00;
    endtask

    initial begin
        // 1: reset, then load 0xC3 and run at speed 1 (period 8)
        #23;
        check("reset pattern", pattern, 8'h00);
        check("reset tick", tick, 1'b0);
        check("reset state", state, S_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        load(8'hC3);
        check("t1 load pattern", pattern, 8'hC3);
        check("t1 load state", state, S_ARMED);
        vel = 2'b01;
        clk_n(1);
        check("t1 state run", state, S_RUN);
        check("t1 no tick edge1", tick, 1'b0);
        count_ticks(6, ticks);
        check("t1 no tick edges2-7", ticks, 0);
        clk_n(1);
        check("t1 tick edge8", tick, 1'b1);
        check("t1 rot1", pattern, 8'h87);
        count_ticks(7, ticks);
        check("t1 no tick between", ticks, 0);
        clk_n(1);
        check("t1 tick2", tick, 1'b1);
        check("t1 rot2", pattern, 8'h0F);

        // 2: load 0x81 at speed 3 (period 2), then stop with speed 0
        vel = 2'b11;
        load(8'h81);
        clk_n(1);
        check("t2 no tick edge1", tick, 1'b0);
        clk_n(1);
        check("t2 tick a", tick, 1'b1);
        check("t2 pat a", pattern, 8'h03);
        clk_n(2);
        check("t2 pat b", pattern, 8'h06);
        clk_n(2);
        check("t2 tick c", tick, 1'b1);
        check("t2 pat c", pattern, 8'h0C);
        vel = 2'b00;
        clk_n(1);
        check("t2 vel0 armed", state, S_ARMED);
        count_ticks(6, ticks);
        check("t2 vel0 no ticks", ticks, 0);
        check("t2 vel0 hold", pattern, 8'h0C);

        // 3: count to 5 at speed 1, switch to speed 3 -> wrap on the next edge
        vel = 2'b01;
        count_ticks(5, ticks);
        check("t3 no tick to 5", ticks, 0);
        vel = 2'b11;
        clk_n(1);
        check("t3 tick on switch", tick, 1'b1);
        check("t3 pat switch", pattern, 8'h18);
        clk_n(1);
        check("t3 gap", tick, 1'b0);
        clk_n(1);
        check("t3 period2 tick", tick, 1'b1);
        check("t3 period2 pat", pattern, 8'h30);

        // 4: pause at count 3 for 10 clocks, then the remaining 5 edges finish the count
        vel = 2'b01;
        clk_n(3);
        pausa = 1'b1;
        count_ticks(10, ticks);
        check("t4 pause no ticks", ticks, 0);
        check("t4 pause state", state, S_PAUSE);
        check("t4 pause pattern", pattern, 8'h30);
        pausa = 1'b0;
        clk_n(1);
        check("t4 resume state", state, S_RUN);
        count_ticks(3, ticks);
        check("t4 resume no early tick", ticks, 0);
        clk_n(1);
        check("t4 resume tick", tick, 1'b1);
        check("t4 resume pat", pattern, 8'h60);

        // 5: zero load while running keeps the pattern and clears the counter
        vel = 2'b11;
        load(8'h87);
        clk_n(2);
        check("t5 pat 0F", pattern, 8'h0F);
        check("t5 run", state, S_RUN);
        load(8'h00);
        check("t5 zero load pat", pattern, 8'h0F);
        check("t5 zero load state", state, S_ARMED);
        check("t5 zero load tick", tick, 1'b0);
        vel = 2'b01;
        count_ticks(7, ticks);
        check("t5 counter cleared", ticks, 0);
        clk_n(1);
        check("t5 tick after 8", tick, 1'b1);
        check("t5 pat 1E", pattern, 8'h1E);
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        count_ticks(10, ticks);
        check("t5 idle no ticks", ticks, 0);
        check("t5 idle state", state, S_IDLE);
        check("t5 idle pattern", pattern, 8'h00);
        pausa = 1'b1;
        clk_n(2);
        check("t5 idle ignores pause", state, S_IDLE);
        pausa = 1'b0;

        // 6: asynchronous reset between edges while TICK is high
        vel = 2'b11;
        load(8'hC3);
        clk_n(2);
        check("t6 tick before reset", tick, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("t6 async pattern", pattern, 8'h00);
        check("t6 async tick", tick, 1'b0);
        check("t6 async state", state, S_IDLE);
        clk_n(1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
